prescaled_updown_counter: RTL and testbench

PRESCALED_UPDOWN_COUNTER -- requirements
Module: prescaled_updown_counter

---
 rtl/prescaled_updown_counter_pkg.sv | 16 +
 rtl/prescaled_updown_counter_if.sv | 31 +++
 rtl/prescaled_updown_counter_prescaler.sv | 38 +++
 rtl/prescaled_updown_counter.sv | 86 ++++++++
 tb/tb_prescaled_updown_counter.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/prescaled_updown_counter_pkg.sv
// Shared constants and types for the prescaled up/down counter.
// Holds the boundary-mode encodings and the direction type used by the count logic.
package prescaled_counter_pkg;

  localparam int WRAP     = 1;
  localparam int SATURATE = 0;

  localparam int DEFAULT_COUNT_W    = 8;
  localparam int DEFAULT_PRESCALE_W = 8;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } direction_e;

endpackage

// File: rtl/prescaled_updown_counter_if.sv
// Control/status bundle for the prescaled up/down counter.
// The master side drives controls; the slave side (the counter) drives status.
interface prescaled_updown_counter_if #(
  parameter int COUNT_W    = 8,
  parameter int PRESCALE_W = 8
);

  logic                  enable_i;
  logic                  clear_i;
  logic                  load_i;
  logic [COUNT_W-1:0]    load_value_i;
  logic                  up_i;
  logic [PRESCALE_W-1:0] prescale_i;

  logic [COUNT_W-1:0]    count_o;
  logic [PRESCALE_W-1:0] prescale_count_o;
  logic                  tick_o;
  logic                  terminal_o;
  logic                  saturated_o;

  modport master (
    output enable_i, clear_i, load_i, load_value_i, up_i, prescale_i,
    input  count_o, prescale_count_o, tick_o, terminal_o, saturated_o
  );

  modport slave (
    input  enable_i, clear_i, load_i, load_value_i, up_i, prescale_i,
    output count_o, prescale_count_o, tick_o, terminal_o, saturated_o
  );

endinterface

// File: rtl/prescaled_updown_counter_prescaler.sv
// Runtime-programmable prescaler: emits a step every divisor+1 enabled cycles.
// The step output is combinational so the parent registers tick on the same edge.
module prescaler #(
  parameter int PRESCALE_W = 8
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  enable_i,
  input  logic                  clear,
  input  logic [PRESCALE_W-1:0] divisor,
  output logic [PRESCALE_W-1:0] count,
  output logic                  step
);

  logic [PRESCALE_W-1:0] count_q;
  logic                  at_divisor;

  // >= rather than == so lowering the divisor below the current count still steps
  assign at_divisor = (count_q >= divisor);

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable_i) begin
      if (at_divisor) begin
        count_q <= '0;
      end else begin
        count_q <= count_q + PRESCALE_W'(1);
      end
    end
  end

  assign step  = enable_i && !clear && at_divisor;
  assign count = count_q;

endmodule

// File: rtl/prescaled_updown_counter.sv
// Up/down counter advanced by a runtime prescaler, with wrap or saturate at the ends.
// Clear beats load beats enable; tick/terminal are single-cycle registered pulses.
module prescaled_updown_counter
  import prescaled_counter_pkg::*;
#(
  parameter int COUNT_W    = DEFAULT_COUNT_W,
  parameter int PRESCALE_W = DEFAULT_PRESCALE_W,
  parameter int WRAP_MODE  = WRAP
) (
  input  logic                    clock_i,
  input  logic                    reset_i,
  prescaled_updown_counter_if.slave bus
);

  localparam logic [COUNT_W-1:0] COUNT_MAX = {COUNT_W{1'b1}};

  logic [COUNT_W-1:0]    count_q;
  logic [COUNT_W-1:0]    count_next;
  logic                  tick_q;
  logic                  terminal_q;
  logic                  at_boundary;
  logic                  step;
  logic                  prescale_clear;
  logic [PRESCALE_W-1:0] prescale_count;
  direction_e            direction;

  assign direction      = direction_e'(bus.up_i);
  assign prescale_clear = bus.clear_i || bus.load_i;

  prescaler #(
    .PRESCALE_W(PRESCALE_W)
  ) u_prescaler (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .enable_i(bus.enable_i),
    .clear   (prescale_clear),
    .divisor (bus.prescale_i),
    .count   (prescale_count),
    .step    (step)
  );

  assign at_boundary = (direction == DIR_UP) ? (count_q == COUNT_MAX)
                                             : (count_q == '0);

  // Natural modulo arithmetic gives the wrap; saturate mode just refuses to move at the end
  always_comb begin
    count_next = count_q;
    if (at_boundary && (WRAP_MODE == SATURATE)) begin
      count_next = count_q;
    end else if (direction == DIR_UP) begin
      count_next = count_q + COUNT_W'(1);
    end else begin
      count_next = count_q - COUNT_W'(1);
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      count_q    <= '0;
      tick_q     <= 1'b0;
      terminal_q <= 1'b0;
    end else if (bus.clear_i) begin
      count_q    <= '0;
      tick_q     <= 1'b0;
      terminal_q <= 1'b0;
    end else if (bus.load_i) begin
      count_q    <= bus.load_value_i;
      tick_q     <= 1'b0;
      terminal_q <= 1'b0;
    end else if (step) begin
      count_q    <= count_next;
      tick_q     <= 1'b1;
      terminal_q <= at_boundary;
    end else begin
      tick_q     <= 1'b0;
      terminal_q <= 1'b0;
    end
  end

  assign bus.count_o          = count_q;
  assign bus.prescale_count_o = prescale_count;
  assign bus.tick_o           = tick_q;
  assign bus.terminal_o       = terminal_q;
  assign bus.saturated_o      = (WRAP_MODE == SATURATE) && at_boundary;

endmodule

// File: tb/tb_prescaled_updown_counter.sv
// Bench for prescaled_updown_counter: a wrapping and a saturating instance share
// identical stimulus and are compared against an arithmetic reference model.
module tb_prescaled_updown_counter;
  import prescaled_counter_pkg::*;

  localparam int CW   = 8;
  localparam int PW   = 8;
  localparam int MAXV = (1 << CW) - 1;

  logic clock_i = 1'b0;
  logic reset_i = 1'b0;

  always #5 clock_i = ~clock_i;

  prescaled_updown_counter_if #(.COUNT_W(CW), .PRESCALE_W(PW)) bus_w ();
  prescaled_updown_counter_if #(.COUNT_W(CW), .PRESCALE_W(PW)) bus_s ();

  prescaled_updown_counter #(.COUNT_W(CW), .PRESCALE_W(PW), .WRAP_MODE(WRAP)) dut_wrap (
    .clock_i(clock_i),
    .reset_i(reset_i),
    .bus    (bus_w)
  );

  prescaled_updown_counter #(.COUNT_W(CW), .PRESCALE_W(PW), .WRAP_MODE(SATURATE)) dut_sat (
    .clock_i(clock_i),
    .reset_i(reset_i),
    .bus    (bus_s)
  );

  int asserts = 0;
  int fails   = 0;

  // index 0 models the wrapping instance, index 1 the saturating one
  int m_count [2];
  int m_pre   [2];
  int m_tick  [2];
  int m_term  [2];

  task automatic applyStimulus(input logic en, input logic clr, input logic ld,
                               input logic [CW-1:0] lv, input logic up,
                               input logic [PW-1:0] ps);
    bus_w.enable_i = en;  bus_s.enable_i = en;
    bus_w.clear_i  = clr; bus_s.clear_i  = clr;
    bus_w.load_i   = ld;  bus_s.load_i   = ld;
    bus_w.load_value_i = lv; bus_s.load_value_i = lv;
    bus_w.up_i     = up;  bus_s.up_i     = up;
    bus_w.prescale_i = ps; bus_s.prescale_i = ps;
  endtask

  task automatic model_zero();
    for (int i = 0; i < 2; i++) begin
      m_count[i] = 0; m_pre[i] = 0; m_tick[i] = 0; m_term[i] = 0;
    end
  endtask

  // One rising edge of behaviour, computed straight from the counting rules
  task automatic model_edge();
    int ps;
    int up;
    int boundary;
    ps = int'(bus_w.prescale_i);
    up = int'(bus_w.up_i);
    for (int i = 0; i < 2; i++) begin
      if (reset_i) begin
        m_count[i] = 0; m_pre[i] = 0; m_tick[i] = 0; m_term[i] = 0;
      end else if (bus_w.clear_i) begin
        m_count[i] = 0; m_pre[i] = 0; m_tick[i] = 0; m_term[i] = 0;
      end else if (bus_w.load_i) begin
        m_count[i] = int'(bus_w.load_value_i); m_pre[i] = 0; m_tick[i] = 0; m_term[i] = 0;
      end else if (bus_w.enable_i) begin
        if (m_pre[i] >= ps) begin
          m_pre[i]  = 0;
          m_tick[i] = 1;
          boundary  = (up == 1) ? int'(m_count[i] == MAXV) : int'(m_count[i] == 0);
          m_term[i] = boundary;
          if (i == 0) begin
            m_count[i] = (up == 1) ? (m_count[i] + 1) % (MAXV + 1)
                                   : (m_count[i] + MAXV) % (MAXV + 1);
          end else if (up == 1) begin
            m_count[i] = (m_count[i] < MAXV) ? m_count[i] + 1 : MAXV;
          end else begin
            m_count[i] = (m_count[i] > 0) ? m_count[i] - 1 : 0;
          end
        end else begin
          m_pre[i]  = m_pre[i] + 1;
          m_tick[i] = 0;
          m_term[i] = 0;
        end
      end else begin
        m_tick[i] = 0;
        m_term[i] = 0;
      end
    end
  endtask

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    asserts++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int sat_expected(input int cnt);
    if (bus_s.up_i) return int'(cnt == MAXV);
    return int'(cnt == 0);
  endfunction

  task automatic checkOutput(input string ctx);
    check_val({ctx, "/w.count"},    32'(bus_w.count_o),          32'(m_count[0]));
    check_val({ctx, "/w.pre"},      32'(bus_w.prescale_count_o), 32'(m_pre[0]));
    check_val({ctx, "/w.tick"},     32'(bus_w.tick_o),           32'(m_tick[0]));
    check_val({ctx, "/w.terminal"}, 32'(bus_w.terminal_o),       32'(m_term[0]));
    check_val({ctx, "/w.sat"},      32'(bus_w.saturated_o),      32'(0));
    check_val({ctx, "/s.count"},    32'(bus_s.count_o),          32'(m_count[1]));
    check_val({ctx, "/s.pre"},      32'(bus_s.prescale_count_o), 32'(m_pre[1]));
    check_val({ctx, "/s.tick"},     32'(bus_s.tick_o),           32'(m_tick[1]));
    check_val({ctx, "/s.terminal"}, 32'(bus_s.terminal_o),       32'(m_term[1]));
    check_val({ctx, "/s.sat"},      32'(bus_s.saturated_o),      32'(sat_expected(m_count[1])));
  endtask

  task automatic run_cycle(input string ctx);
    @(posedge clock_i);
    model_edge();
    #1;
    checkOutput(ctx);
    @(negedge clock_i);
  endtask

  initial begin
    int tick_cnt;
    int first_tick;
    int r;
    logic [CW-1:0] lv;
    logic [PW-1:0] ps;

    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1, '0);
    #2 reset_i = 1'b1;
    #1;
    model_zero();
    checkOutput("reset");
    @(negedge clock_i);
    run_cycle("reset_hold");
    reset_i = 1'b0;

    // 80 enabled cycles at divide-by-8
    $display("[TB] basic count-up");
    applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b1, 8'd7);
    tick_cnt = 0;
    repeat (80) begin
      run_cycle("basic");
      if (bus_w.tick_o) tick_cnt++;
    end
    check_val("basic_final_count", 32'(bus_w.count_o), 32'd10);
    check_val("basic_tick_total", 32'(tick_cnt), 32'd10);

    $display("[TB] wrap at top");
    applyStimulus(1'b0, 1'b0, 1'b1, 8'hFE, 1'b1, 8'd0);
    run_cycle("wrap_load");
    applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b1, 8'd0);
    run_cycle("wrap1");
    check_val("wrap_ff", 32'(bus_w.count_o), 32'hFF);
    run_cycle("wrap2");
    check_val("wrap_00", 32'(bus_w.count_o), 32'h00);
    check_val("wrap_00_terminal", 32'(bus_w.terminal_o), 32'd1);
    run_cycle("wrap3");
    check_val("wrap_01", 32'(bus_w.count_o), 32'h01);

    $display("[TB] saturate at bottom");
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h01, 1'b0, 8'd0);
    run_cycle("sat_load");
    applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0, 8'd0);
    repeat (4) run_cycle("sat");
    check_val("sat_held_zero", 32'(bus_s.count_o), 32'd0);
    check_val("sat_level", 32'(bus_s.saturated_o), 32'd1);

    $display("[TB] priority clear>load>enable");
    applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b1, 8'd3);
    repeat (2) run_cycle("prio_pre");
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h55, 1'b1, 8'd0);
    run_cycle("prio");
    check_val("prio_count", 32'(bus_w.count_o), 32'd0);
    check_val("prio_pre", 32'(bus_w.prescale_count_o), 32'd0);

    $display("[TB] runtime divisor reduction");
    applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b1, 8'd7);
    repeat (5) run_cycle("div_fill");
    check_val("div_pre5", 32'(bus_w.prescale_count_o), 32'd5);
    applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b1, 8'd2);
    run_cycle("div_step");
    check_val("div_tick", 32'(bus_w.tick_o), 32'd1);

    $display("[TB] async reset mid-prescale");
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h33, 1'b1, 8'd3);
    run_cycle("ar_load");
    applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b1, 8'd3);
    repeat (2) run_cycle("ar_pre");
    check_val("ar_count33", 32'(bus_w.count_o), 32'h33);
    #2 reset_i = 1'b1;
    #1;
    model_zero();
    checkOutput("ar_async");
    run_cycle("ar_held");
    reset_i = 1'b0;
    first_tick = 0;
    for (int e = 1; e <= 12 && first_tick == 0; e++) begin
      run_cycle("ar_resume");
      if (bus_w.tick_o) first_tick = e;
    end
    check_val("ar_first_step_edge", 32'(first_tick), 32'd4);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 500; n++) begin
      r = int'($urandom_range(0, 99));
      case ($urandom_range(0, 4))
        0: lv = 8'h00;
        1: lv = 8'h01;
        2: lv = 8'hFE;
        3: lv = 8'hFF;
        default: lv = CW'($urandom);
      endcase
      ps = ($urandom_range(0, 19) == 0) ? PW'($urandom_range(0, 12)) : PW'($urandom_range(0, 3));
      applyStimulus(($urandom_range(0, 9) < 8), (r < 3), (r >= 3 && r < 8), lv,
                    1'($urandom_range(0, 1)), ps);
      if (r == 99) begin
        #2 reset_i = 1'b1;
        #1;
        model_zero();
        checkOutput("rnd_async");
        run_cycle("rnd_reset");
        reset_i = 1'b0;
      end else begin
        run_cycle("rnd");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
